// File: rtl/udp_ip_packer.sv
// Prepends a 20-byte IPv4 header and an 8-byte UDP header to a payload byte stream (8-bit AXI-Stream).
// Optional: define UDP_IP_ID_INC_EN to make the IPv4 identification field count packets instead of staying 0.
module udp_ip_packer #(
  parameter logic [7:0] TTL    = 8'd64,
  parameter logic       DF_BIT = 1'b1
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_areset,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic [15:0] payload_len,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        len_err
);

  typedef enum logic [2:0] {ST_IDLE, ST_CSUM1, ST_CSUM2, ST_HDR, ST_DATA} state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] src_ip_q, dst_ip_q;
  logic [15:0] src_port_q, dst_port_q, plen_q, total_len_q, udp_len_q;
  logic [31:0] sum_q, sum_d;
  logic [16:0] fold1;
  logic [15:0] fold2, csum_q, cnt_q, ip_id;
  logic        len_err_q;
  logic [7:0]  hdr_byte;
  logic        s_acc;

  assign s_acc = s_axis_tvalid & s_axis_tready;

`ifdef UDP_IP_ID_INC_EN
  logic [15:0] ip_id_q;
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      ip_id_q <= 16'h0000;
    end else if (state_q == ST_HDR && idx_q == 5'd27 && m_axis_tready) begin
      ip_id_q <= ip_id_q + 16'd1;
    end
  end
  assign ip_id = ip_id_q;
`else
  assign ip_id = 16'h0000;
`endif

  // Flags/offset word carries DF in bit 14; fragment offset is always zero.
  assign sum_d = 32'h0000_4500 + 32'(total_len_q) + 32'(ip_id)
               + 32'({1'b0, DF_BIT, 14'h0000}) + 32'({TTL, 8'h11})
               + 32'(src_ip_q[31:16]) + 32'(src_ip_q[15:0])
               + 32'(dst_ip_q[31:16]) + 32'(dst_ip_q[15:0]);
  assign fold1 = {1'b0, sum_q[15:0]} + {1'b0, sum_q[31:16]};
  assign fold2 = fold1[15:0] + {15'h0000, fold1[16]};

  always_comb begin
    case (idx_q)
      5'd0:    hdr_byte = 8'h45;
      5'd2:    hdr_byte = total_len_q[15:8];
      5'd3:    hdr_byte = total_len_q[7:0];
      5'd4:    hdr_byte = ip_id[15:8];
      5'd5:    hdr_byte = ip_id[7:0];
      5'd6:    hdr_byte = {1'b0, DF_BIT, 6'h00};
      5'd8:    hdr_byte = TTL;
      5'd9:    hdr_byte = 8'h11;
      5'd10:   hdr_byte = csum_q[15:8];
      5'd11:   hdr_byte = csum_q[7:0];
      5'd12:   hdr_byte = src_ip_q[31:24];
      5'd13:   hdr_byte = src_ip_q[23:16];
      5'd14:   hdr_byte = src_ip_q[15:8];
      5'd15:   hdr_byte = src_ip_q[7:0];
      5'd16:   hdr_byte = dst_ip_q[31:24];
      5'd17:   hdr_byte = dst_ip_q[23:16];
      5'd18:   hdr_byte = dst_ip_q[15:8];
      5'd19:   hdr_byte = dst_ip_q[7:0];
      5'd20:   hdr_byte = src_port_q[15:8];
      5'd21:   hdr_byte = src_port_q[7:0];
      5'd22:   hdr_byte = dst_port_q[15:8];
      5'd23:   hdr_byte = dst_port_q[7:0];
      5'd24:   hdr_byte = udp_len_q[15:8];
      5'd25:   hdr_byte = udp_len_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = 5'd0;
        if (s_axis_tvalid && s_axis_tuser) state_d = ST_CSUM1;
      end
      ST_CSUM1: state_d = ST_CSUM2;
      ST_CSUM2: state_d = ST_HDR;
      ST_HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_byte;
        m_axis_tuser  = (idx_q == 5'd0);
        if (m_axis_tready) begin
          if (idx_q == 5'd27) begin
            idx_d   = 5'd0;
            state_d = ST_DATA;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        s_axis_tready = m_axis_tready;
        if (s_acc && s_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_q     <= ST_IDLE;
      idx_q       <= 5'd0;
      src_ip_q    <= 32'h0;
      dst_ip_q    <= 32'h0;
      src_port_q  <= 16'h0;
      dst_port_q  <= 16'h0;
      plen_q      <= 16'h0;
      total_len_q <= 16'h0;
      udp_len_q   <= 16'h0;
      sum_q       <= 32'h0;
      csum_q      <= 16'h0;
      cnt_q       <= 16'h0;
      len_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_err_q <= 1'b0;
      if (state_q == ST_IDLE && s_axis_tvalid && s_axis_tuser) begin
        src_ip_q    <= src_ip;
        dst_ip_q    <= dst_ip;
        src_port_q  <= src_port;
        dst_port_q  <= dst_port;
        plen_q      <= payload_len;
        total_len_q <= payload_len + 16'd28;
        udp_len_q   <= payload_len + 16'd8;
      end
      if (state_q == ST_CSUM1) sum_q <= sum_d;
      if (state_q == ST_CSUM2) csum_q <= ~fold2;
      // The mismatch test includes the tlast beat itself in the count.
      if (state_q == ST_DATA) begin
        if (s_acc) begin
          cnt_q <= cnt_q + 16'd1;
          if (s_axis_tlast) begin
            cnt_q     <= 16'h0;
            len_err_q <= (cnt_q + 16'd1 != plen_q);
          end
        end
      end else begin
        cnt_q <= 16'h0;
      end
    end
  end

  assign len_err = len_err_q;

endmodule

// File: tb/tb_udp_ip_packer.sv
// Scoreboard bench for udp_ip_packer: driver pushes expected beats, a negedge monitor pops and compares.
module tb_udp_ip_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] src_ip = '0, dst_ip = '0;
  logic [15:0] src_port = '0, dst_port = '0, payload_len = '0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, len_err;
  logic        m_axis_tready = 1'b1;

  always #5 clk = ~clk;

  udp_ip_packer dut (
    .s_axis_aclk  (clk),
    .s_axis_areset(rst),
    .src_ip       (src_ip),
    .dst_ip       (dst_ip),
    .src_port     (src_port),
    .dst_port     (dst_port),
    .payload_len  (payload_len),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .len_err      (len_err)
  );

  int          n_checks = 0, n_fail = 0;
  int          cyc = 0, start_cyc = 0, beats = 0, len_err_cnt = 0;
  bit          lat_pending = 1'b0, stall_pend = 1'b0, bp_en = 1'b0;
  logic [9:0]  stall_data = '0;
  logic [9:0]  exp_q[$];
  logic [15:0] tb_id = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'h0, s[16]};
  endfunction

  // Expected header: either a hand-written byte string or built field by field.
  task automatic push_hdr(input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sp,
                          input logic [15:0] dp, input logic [15:0] plen, input bit use_lit);
    logic [7:0]   h[28];
    logic [15:0]  wds[9];
    logic [15:0]  acc, tl, ul;
    logic [223:0] lit;
    lit = 224'h4500002E_00004000_4011B763_C0A8010A_C0A80101_04D2162E_001A0000;
    tl = plen + 16'd28;
    ul = plen + 16'd8;
    wds = '{16'h4500, tl, tb_id, 16'h4000, 16'h4011, sip[31:16], sip[15:0], dip[31:16], dip[15:0]};
    acc = 16'h0;
    for (int k = 0; k < 9; k++) acc = oc_add(acc, wds[k]);
    acc = ~acc;
    h = '{8'h45, 8'h00, tl[15:8], tl[7:0], tb_id[15:8], tb_id[7:0], 8'h40, 8'h00, 8'h40, 8'h11,
          acc[15:8], acc[7:0], sip[31:24], sip[23:16], sip[15:8], sip[7:0],
          dip[31:24], dip[23:16], dip[15:8], dip[7:0], sp[15:8], sp[7:0], dp[15:8], dp[7:0],
          ul[15:8], ul[7:0], 8'h00, 8'h00};
    for (int k = 0; k < 28; k++) begin
      if (use_lit) exp_q.push_back({lit[223-8*k -: 8], 1'b0, k == 0});
      else         exp_q.push_back({h[k], 1'b0, k == 0});
    end
`ifdef UDP_IP_ID_INC_EN
    tb_id = tb_id + 16'd1;
`endif
  endtask

  task automatic send_pkt(input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sp,
                          input logic [15:0] dp, input logic [15:0] plen, input int nbytes,
                          input bit do_last, input bit use_lit, input logic [7:0] base);
    for (int i = 0; i < nbytes; i++) begin
      int         w;
      bit         acc;
      logic [7:0] b;
      bit         lst;
      b   = base + 8'(i);
      lst = do_last && (i == nbytes - 1);
      @(negedge clk);
      if (i == 0) begin
        src_ip = sip; dst_ip = dip; src_port = sp; dst_port = dp; payload_len = plen;
        push_hdr(sip, dip, sp, dp, plen, use_lit);
        start_cyc   = cyc;
        lat_pending = 1'b1;
      end
      s_axis_tdata = b; s_axis_tvalid = 1'b1; s_axis_tlast = lst; s_axis_tuser = (i == 0);
      exp_q.push_back({b, lst, 1'b0});
      w = 0; acc = 1'b0;
      while (!acc) begin
        #1;
        if (s_axis_tready) acc = 1'b1;
        else begin
          w++;
          if (w > 2000) begin
            n_checks++; n_fail++;
            $display("FAIL payload_accept_timeout: byte %0d never accepted, want accept within 2000 cycles", i);
            s_axis_tvalid = 1'b0;
            return;
          end
          @(negedge clk);
        end
      end
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 1000) begin
      @(posedge clk);
      w++;
    end
    repeat (4) @(posedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_s_tready"}, s_axis_tready, 0);
    chk({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_m_tdata"},  m_axis_tdata, 0);
    chk({tag, "_m_tlast"},  m_axis_tlast, 0);
    chk({tag, "_m_tuser"},  m_axis_tuser, 0);
    chk({tag, "_len_err"},  len_err, 0);
  endtask

  // Monitor: scoreboard pops, stall stability, header latency, len_err pulse count.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (len_err) len_err_cnt++;
      if (stall_pend) chk("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser},
                          {1'b1, stall_data});
      if (lat_pending && m_axis_tvalid && m_axis_tuser) begin
        chk("hdr0_latency", 32'(cyc - start_cyc), 3);
        lat_pending = 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_extra: got beat %h last=%b user=%b, want no beat",
                   m_axis_tdata, m_axis_tlast, m_axis_tuser);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} !== e) begin
            n_fail++;
            $display("FAIL scoreboard_beat: got %h last=%b user=%b, want %h last=%b user=%b",
                     m_axis_tdata, m_axis_tlast, m_axis_tuser, e[9:2], e[1], e[0]);
          end
        end
      end
      stall_pd_update: begin
        stall_pend = m_axis_tvalid && !m_axis_tready;
        stall_data = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000 time units, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int le0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk_outputs_zero("reset");
    rst = 1'b0;

    // Single packet, hand-written header
    beats = 0; le0 = len_err_cnt;
    send_pkt(32'hC0A8010A, 32'hC0A80101, 16'd1234, 16'd5678, 16'd18, 18, 1'b1, 1'b1, 8'h00);
    drain("single_drain");
    chk("single_beats", beats, 46);
    chk("single_len_err", len_err_cnt - le0, 0);

    // Same packet under random backpressure
    bp_en = 1'b1; beats = 0; le0 = len_err_cnt;
    send_pkt(32'hC0A8010A, 32'hC0A80101, 16'd1234, 16'd5678, 16'd18, 18, 1'b1, 1'b0, 8'h00);
    drain("bp_drain");
    bp_en = 1'b0;
    chk("bp_beats", beats, 46);
    chk("bp_len_err", len_err_cnt - le0, 0);

    // Early tlast: 10 of 18 bytes
    beats = 0; le0 = len_err_cnt;
    send_pkt(32'h0A000001, 32'h0A0000FE, 16'h0400, 16'h0035, 16'd18, 10, 1'b1, 1'b0, 8'h40);
    drain("mismatch_drain");
    chk("mismatch_beats", beats, 38);
    chk("mismatch_len_err", len_err_cnt - le0, 1);

    // Back-to-back packets; latency of the second header is checked by the monitor
    beats = 0; le0 = len_err_cnt;
    send_pkt(32'h01020304, 32'hFFFFFFFF, 16'hFFFF, 16'h0001, 16'd4, 4, 1'b1, 1'b0, 8'hA0);
    send_pkt(32'hAC100001, 32'hAC1000FF, 16'h1F90, 16'hC000, 16'd6, 6, 1'b1, 1'b0, 8'hF8);
    drain("b2b_drain");
    chk("b2b_beats", beats, 66);
    chk("b2b_len_err", len_err_cnt - le0, 0);

    // Reset mid-DATA, then a fresh packet
    beats = 0;
    send_pkt(32'hC0A80002, 32'hC0A80003, 16'd100, 16'd200, 16'd18, 5, 1'b0, 1'b0, 8'h10);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #2;
    chk_outputs_zero("midreset");
    chk("midreset_beats", beats, 33);
    chk("midreset_queue", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    tb_id = 16'h0000;
    beats = 0; le0 = len_err_cnt;
    send_pkt(32'hC0A8010A, 32'hC0A80101, 16'd1234, 16'd5678, 16'd18, 18, 1'b1, 1'b1, 8'h00);
    drain("postreset_drain");
    chk("postreset_beats", beats, 46);
    chk("postreset_len_err", len_err_cnt - le0, 0);

    // Single-byte payload
    beats = 0; le0 = len_err_cnt;
    send_pkt(32'hC0A8010A, 32'hC0A80101, 16'd1234, 16'd5678, 16'd1, 1, 1'b1, 1'b0, 8'h5A);
    drain("len1_drain");
    chk("len1_beats", beats, 29);
    chk("len1_len_err", len_err_cnt - le0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
